spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Downstream stage of the AHB slave control unit. Pops 41-bit command entries from the write FIFO (AHB->SPI).
//  Serialises each entry as one SPI mode-0 frame; for read commands, captures 32 MISO bits into the read FIFO.
//  Entry format: [40]=RW (1 write, 0 read), [39:32]=address byte, [31:0]=write data (ignored for reads).
// PARAMETERS
//  CLK_DIV  2  HCLK cycles per SCLK half-period; legal range >=1
//  CS_GAP   4  minimum HCLK cycles SPI_CS_n stays high between frames; legal range >=1
// PORTS
//  HCLK                 in   1   system clock; every flop is clocked on its rising edge
//  HRESETn              in   1   asynchronous active-low reset
//  DATA_from_WriteFIFO  in   41  write-FIFO output; valid one HCLK after WriteFIFO_rd_en
//  WriteFIFO_empty      in   1   write FIFO has no entries
//  WriteFIFO_rd_en      out  1   one-cycle pop strobe
//  DATA_to_ReadFIFO     out  32  captured read data
//  ReadFIFO_wr_en       out  1   one-cycle push strobe
//  ReadFIFO_full        in   1   read FIFO cannot accept data
//  SPI_SCLK             out  1   serial clock, idles low
//  SPI_CS_n             out  1   chip select, active low
//  SPI_MOSI             out  1   serial data out, MSB first
//  SPI_MISO             in   1   serial data in
//  SPI_busy             out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: SPI_CS_n=1, SPI_SCLK=0, SPI_MOSI=0, WriteFIFO_rd_en=0, ReadFIFO_wr_en=0.
//  Reset (cont.): DATA_to_ReadFIFO=0, SPI_busy=0, state=IDLE.
//  Reset is honoured mid-frame: all outputs return to reset values immediately. The partial frame is discarded.
//  All outputs are registered.
//  FSM states: IDLE, FETCH, LOAD, CS_SETUP, SHIFT, CS_HOLD, PUSH, GAP.
//  IDLE: if !WriteFIFO_empty, assert WriteFIFO_rd_en for exactly 1 cycle and go to FETCH.
//  FETCH: wait 1 cycle for FIFO data (rd_en=0) -> LOAD.
//  LOAD: latch DATA_from_WriteFIFO into a 41-bit tx shift register. Drive SPI_CS_n=0 and SPI_MOSI=tx[40]. -> CS_SETUP.
//  CS_SETUP: hold for CLK_DIV cycles with SCLK low -> SHIFT, bit counter=40.
//  SHIFT: each bit = CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
//    Rising edge of SCLK: if RW=0 and counter<=31, shift SPI_MISO into rx[0] (rx shifts left).
//    Falling edge (end of high phase): counter decrements; MOSI presents the next bit.
//    For RW=0, MOSI=0 during data bits 31..0.
//    After bit 0 high phase: SCLK=0 -> CS_HOLD.
//  Frame length: exactly 41 SCLK rising edges. Order: RW, addr[7]..addr[0], data[31]..data[0].
//  CS_HOLD: CLK_DIV cycles, then SPI_CS_n=1. Next state: PUSH if RW=0, else GAP.
//  PUSH: if !ReadFIFO_full, drive DATA_to_ReadFIFO=rx and ReadFIFO_wr_en=1 for 1 cycle -> GAP.
//    Otherwise stall in PUSH (CS high, no data lost) until full deasserts.
//  GAP: CS_GAP cycles with CS high -> IDLE. A new entry is never popped before GAP completes.
//  Data is never dropped: no pop occurs while a frame or pending push is outstanding.
//    Max one entry is in flight at a time.
//  Latency, CLK_DIV=D: rd_en -> CS_n low = 2 cycles. CS_n low duration = D + 82*D + D cycles.
//  WriteFIFO_empty asserting during a frame has no effect on that frame.
// TESTING
//  T1 (D=2): write entry {1,8'hA5,32'hDEADBEEF} -> MOSI samples at the 41 rising edges = 1,A5,DEADBEEF MSB-first.
//    T1 checks (cont.): CS_n low 168 cycles; ReadFIFO_wr_en never asserts.
//  T2: read entry {0,8'h3C,32'h0}, MISO model returns 32'h12345678 -> MOSI = 0,3C, then 32 zeros.
//    T2 checks (cont.): one ReadFIFO_wr_en pulse with DATA_to_ReadFIFO=32'h12345678, asserted after CS_n rises.
//  T3: ReadFIFO_full=1 throughout a read frame and for 10 extra cycles -> wr_en held low, SPI_busy=1.
//    T3 checks (cont.): push of the correct data on the first cycle after full deasserts.
//  T4: three back-to-back entries -> exactly 3 rd_en pulses; CS_n high >=CS_GAP cycles between frames.
//    T4 checks (cont.): frames are in FIFO order.
//  T5: HRESETn low at bit 20 of a frame -> CS_n=1, SCLK=0, MOSI=0 without waiting for a clock edge.
//    T5 checks (cont.): no ReadFIFO_wr_en; after release, the next entry is sent cleanly.
//  T6: WriteFIFO_empty=1 held for 100 cycles -> no rd_en, CS_n=1, SPI_busy=0.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// Drains 41-bit command entries from the AHB->SPI write FIFO and sends each one
// as a single SPI mode-0 frame: RW bit, address byte, then 32 data bits, MSB first.
// Read commands capture 32 MISO bits and push them into the read FIFO once the
// frame has closed. Only one entry is in flight at a time.
module spi_master_ctrl #(
    parameter int CLK_DIV = 2,  // HCLK cycles per SCLK half-period (>= 1)
    parameter int CS_GAP  = 4   // minimum HCLK cycles with CS high between frames (>= 1)
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [40:0] DATA_from_WriteFIFO,
    input  logic        WriteFIFO_empty,
    output logic        WriteFIFO_rd_en,
    output logic [31:0] DATA_to_ReadFIFO,
    output logic        ReadFIFO_wr_en,
    input  logic        ReadFIFO_full,
    output logic        SPI_SCLK,
    output logic        SPI_CS_n,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_busy
);

    // One counter serves the SCLK half-periods, the CS setup/hold and the CS gap.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        PUSH,
        GAP
    } state_t;

    state_t           state;
    logic             rw;        // 1 = write frame, 0 = read frame
    logic [39:0]      tx_shift;  // bits still to send after the one on MOSI
    logic [31:0]      rx_shift;  // MISO bits captured so far, newest in bit 0
    logic [5:0]       bit_cnt;   // index of the bit currently on the wire (40..0)
    logic [CNT_W-1:0] cnt;

    // Frame sequencer: every output is a flop written only from this block.
    // NOTE: all state here uses non-blocking assignments so each flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: the asynchronous reset clears every flop, so a frame cut short by
        // reset leaves nothing behind that could leak into the next frame.
        if (!HRESETn) begin
            state            <= IDLE;
            rw               <= 1'b0;
            tx_shift         <= '0;
            rx_shift         <= '0;
            bit_cnt          <= '0;
            cnt              <= '0;
            WriteFIFO_rd_en  <= 1'b0;
            DATA_to_ReadFIFO <= '0;
            ReadFIFO_wr_en   <= 1'b0;
            SPI_SCLK         <= 1'b0;
            SPI_CS_n         <= 1'b1;
            SPI_MOSI         <= 1'b0;
            SPI_busy         <= 1'b0;
        end else begin
            // NOTE: FIFO strobes default low every cycle, which makes them single-cycle
            // pulses without any extra clearing logic in the states.
            WriteFIFO_rd_en <= 1'b0;
            ReadFIFO_wr_en  <= 1'b0;

            case (state)
                IDLE: begin
                    if (!WriteFIFO_empty) begin
                        WriteFIFO_rd_en <= 1'b1;
                        SPI_busy        <= 1'b1;
                        state           <= FETCH;
                    end
                end

                FETCH: begin
                    // FIFO output becomes valid one cycle after the pop strobe.
                    state <= LOAD;
                end

                LOAD: begin
                    rw       <= DATA_from_WriteFIFO[40];
                    // Reads send zeros in the data field, so blank it at load time.
                    tx_shift <= DATA_from_WriteFIFO[40] ? DATA_from_WriteFIFO[39:0]
                                                        : {DATA_from_WriteFIFO[39:32], 32'h0};
                    SPI_CS_n <= 1'b0;
                    SPI_MOSI <= DATA_from_WriteFIFO[40];
                    cnt      <= '0;
                    state    <= CS_SETUP;
                end

                CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= 6'd40;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!SPI_SCLK) begin
                            // End of low phase: SCLK rises, slave data is sampled.
                            SPI_SCLK <= 1'b1;
                            if (!rw && (bit_cnt <= 6'd31)) begin
                                rx_shift <= {rx_shift[30:0], SPI_MISO};
                            end
                        end else begin
                            // End of high phase: SCLK falls, next bit goes out.
                            SPI_SCLK <= 1'b0;
                            if (bit_cnt == 6'd0) begin
                                SPI_MOSI <= 1'b0;
                                state    <= CS_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt - 6'd1;
                                SPI_MOSI <= tx_shift[39];
                                tx_shift <= {tx_shift[38:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                CS_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        SPI_CS_n <= 1'b1;
                        state    <= rw ? GAP : PUSH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PUSH: begin
                    // Stall here while the read FIFO is full; the captured word is kept.
                    if (!ReadFIFO_full) begin
                        DATA_to_ReadFIFO <= rx_shift;
                        ReadFIFO_wr_en   <= 1'b1;
                        cnt              <= '0;
                        state            <= GAP;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        SPI_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed sequence with randomized entries around spi_master_ctrl. A write-FIFO
// model feeds entries, a mode-0 slave model answers reads, and a bus monitor
// rebuilds each frame from SCLK/MOSI so it can be compared with the entry that
// produced it.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 4;
    localparam int T       = 10;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [40:0] DATA_from_WriteFIFO = '0;
    logic        WriteFIFO_empty;
    logic        WriteFIFO_rd_en;
    logic [31:0] DATA_to_ReadFIFO;
    logic        ReadFIFO_wr_en;
    logic        ReadFIFO_full = 1'b0;
    logic        SPI_SCLK;
    logic        SPI_CS_n;
    logic        SPI_MOSI;
    logic        SPI_MISO = 1'b0;
    logic        SPI_busy;

    spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .HCLK                (HCLK),
        .HRESETn             (HRESETn),
        .DATA_from_WriteFIFO (DATA_from_WriteFIFO),
        .WriteFIFO_empty     (WriteFIFO_empty),
        .WriteFIFO_rd_en     (WriteFIFO_rd_en),
        .DATA_to_ReadFIFO    (DATA_to_ReadFIFO),
        .ReadFIFO_wr_en      (ReadFIFO_wr_en),
        .ReadFIFO_full       (ReadFIFO_full),
        .SPI_SCLK            (SPI_SCLK),
        .SPI_CS_n            (SPI_CS_n),
        .SPI_MOSI            (SPI_MOSI),
        .SPI_MISO            (SPI_MISO),
        .SPI_busy            (SPI_busy)
    );

    always #(T/2) HCLK = ~HCLK;

    // ---------------- write FIFO model ----------------
    logic [40:0] wmem [64];
    int          wq_wr = 0;
    int          wq_rd = 0;
    assign WriteFIFO_empty = (wq_wr == wq_rd);

    // Pop: data appears one HCLK after the strobe is seen.
    always @(posedge HCLK) begin
        if (WriteFIFO_rd_en && (wq_rd != wq_wr)) begin
            DATA_from_WriteFIFO <= wmem[wq_rd % 64];
            wq_rd               <= wq_rd + 1;
        end
    end

    // ---------------- SPI slave model and frame monitor ----------------
    logic [31:0] miso_tab [64];   // MISO word answered by frame n
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b0;
    int          mon_edges = 0;
    logic [40:0] mon_bits  = '0;
    time         cs_fall_t = 0;
    int          st_n      = 0;   // frames started (including aborted ones)
    logic [40:0] fr_bits [$];
    int          fr_edges[$];
    time         fr_fall [$];
    time         fr_rise [$];

    // Tracks SCLK/CS edges: records MOSI on rising SCLK, drives MISO after falling SCLK.
    always @(SPI_SCLK or SPI_CS_n) begin
        if (prev_cs === 1'b1 && SPI_CS_n === 1'b0) begin
            mon_edges = 0;
            mon_bits  = '0;
            cs_fall_t = $time;
            st_n++;
            SPI_MISO  = 1'b0;
        end
        if (prev_sclk === 1'b0 && SPI_SCLK === 1'b1 && SPI_CS_n === 1'b0) begin
            mon_bits = {mon_bits[39:0], SPI_MOSI};
            mon_edges++;
        end
        if (prev_sclk === 1'b1 && SPI_SCLK === 1'b0 && SPI_CS_n === 1'b0) begin
            // Rising edges 10..41 carry response bits 31..0.
            if (mon_edges >= 9 && mon_edges <= 40)
                SPI_MISO = miso_tab[(st_n - 1) % 64][40 - mon_edges];
        end
        if (prev_cs === 1'b0 && SPI_CS_n === 1'b1 && HRESETn === 1'b1) begin
            fr_bits.push_back(mon_bits);
            fr_edges.push_back(mon_edges);
            fr_fall.push_back(cs_fall_t);
            fr_rise.push_back($time);
        end
        prev_sclk = SPI_SCLK;
        prev_cs   = SPI_CS_n;
    end

    // ---------------- FIFO strobe monitor ----------------
    int          rd_cnt    = 0;
    time         rd_t_last = 0;
    logic [31:0] wr_q [$];
    time         wr_t [$];
    logic        wr_cs[$];

    // Samples strobes mid-cycle, away from the active edge.
    always @(negedge HCLK) begin
        if (WriteFIFO_rd_en === 1'b1) begin
            rd_cnt++;
            rd_t_last = $time - T/2;
        end
        if (ReadFIFO_wr_en === 1'b1) begin
            wr_q.push_back(DATA_to_ReadFIFO);
            wr_t.push_back($time);
            wr_cs.push_back(SPI_CS_n);
        end
    end

    // ---------------- reference model and helpers ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          next_frame = 0;
    logic [31:0] exp_rd[$];

    // Expected MOSI stream: RW, address, then data for writes or zeros for reads.
    function automatic logic [40:0] exp_mosi(input logic [40:0] e);
        return e[40] ? e : {e[40:32], 32'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic push_entry(input logic [40:0] e, input logic [31:0] miso);
        miso_tab[next_frame % 64] = miso;
        next_frame++;
        wmem[wq_wr % 64] = e;
        wq_wr++;
        if (!e[40]) exp_rd.push_back(miso);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int k = 0;
        while (fr_bits.size() < target && k < 400 * 8) begin
            tick();
            k++;
        end
        check({tag, "_frame_timeout"}, 64'(fr_bits.size() >= target), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!(SPI_busy == 1'b0 && WriteFIFO_empty) && k < 400) begin
            tick();
            k++;
        end
        check({tag, "_idle_timeout"}, 64'(SPI_busy == 1'b0), 64'd1);
    endtask

    task automatic check_frame(input int idx, input logic [40:0] e, input string tag);
        if (idx < fr_bits.size()) begin
            check({tag, "_mosi"},  64'(fr_bits[idx]), 64'(exp_mosi(e)));
            check({tag, "_edges"}, 64'(fr_edges[idx]), 64'd41);
            check({tag, "_cs_low"}, (fr_rise[idx] - fr_fall[idx]) / T,
                  64'(CLK_DIV + 82 * CLK_DIV + CLK_DIV));
        end else begin
            check({tag, "_missing"}, 64'(fr_bits.size()), 64'(idx + 1));
        end
    endtask

    function automatic logic [40:0] rand_entry(input logic rw);
        logic [7:0]  a;
        logic [31:0] d;
        a = 8'($urandom_range(255));
        d = $urandom;
        return {rw, a, d};
    endfunction

    // ---------------- directed sequence ----------------
    logic [40:0] e;
    logic [40:0] e4 [3];
    logic [31:0] m;
    int          base_wr;
    int          base_rd;
    int          viol_a;
    int          viol_b;
    int          viol_c;

    initial begin
        HRESETn = 1'b0;
        repeat (3) tick();
        check("rst_cs_n",  64'(SPI_CS_n), 64'd1);
        check("rst_sclk",  64'(SPI_SCLK), 64'd0);
        check("rst_mosi",  64'(SPI_MOSI), 64'd0);
        check("rst_rd_en", 64'(WriteFIFO_rd_en), 64'd0);
        check("rst_wr_en", 64'(ReadFIFO_wr_en), 64'd0);
        check("rst_rdata", 64'(DATA_to_ReadFIFO), 64'd0);
        check("rst_busy",  64'(SPI_busy), 64'd0);
        HRESETn = 1'b1;
        tick();

        // T1: fixed write frame
        e = {1'b1, 8'hA5, 32'hDEADBEEF};
        base_wr = wr_q.size();
        base_rd = rd_cnt;
        push_entry(e, 32'h0);
        wait_frames(1, "t1");
        check_frame(0, e, "t1");
        if (fr_fall.size() > 0)
            check("t1_rd_to_cs", fr_fall[0] - rd_t_last, 64'(2 * T));
        wait_idle("t1");
        check("t1_no_push", 64'(wr_q.size()), 64'(base_wr));
        check("t1_rd_pulses", 64'(rd_cnt), 64'(base_rd + 1));

        // T2: fixed read frame
        e = {1'b0, 8'h3C, 32'h0};
        push_entry(e, 32'h12345678);
        wait_frames(2, "t2");
        check_frame(1, e, "t2");
        wait_idle("t2");
        check("t2_push_count", 64'(wr_q.size()), 64'(base_wr + 1));
        if (wr_q.size() > base_wr && fr_rise.size() > 1) begin
            check("t2_rdata", 64'(wr_q[base_wr]), 64'h12345678);
            check("t2_push_cs_high", 64'(wr_cs[base_wr]), 64'd1);
            check("t2_push_after_cs", 64'(wr_t[base_wr] > fr_rise[1]), 64'd1);
        end

        // T3: read frame with the read FIFO full throughout
        ReadFIFO_full = 1'b1;
        e = rand_entry(1'b0);
        m = $urandom;
        base_wr = wr_q.size();
        push_entry(e, m);
        wait_frames(3, "t3");
        check_frame(2, e, "t3");
        viol_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ReadFIFO_wr_en !== 1'b0 || SPI_busy !== 1'b1) viol_a++;
        end
        check("t3_stall", 64'(viol_a), 64'd0);
        check("t3_no_push_while_full", 64'(wr_q.size()), 64'(base_wr));
        ReadFIFO_full = 1'b0;
        tick();
        check("t3_push_strobe", 64'(ReadFIFO_wr_en), 64'd1);
        check("t3_push_data", 64'(DATA_to_ReadFIFO), 64'(m));
        wait_idle("t3");

        // T4: three back-to-back random entries
        base_rd = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            e4[i] = rand_entry(1'($urandom_range(1)));
            push_entry(e4[i], $urandom);
        end
        wait_frames(6, "t4");
        for (int i = 0; i < 3; i++) check_frame(3 + i, e4[i], $sformatf("t4_f%0d", i));
        for (int i = 0; i < 2; i++) begin
            if (fr_fall.size() > 4 + i)
                check($sformatf("t4_gap%0d", i),
                      64'((fr_fall[4 + i] - fr_rise[3 + i]) / T >= CS_GAP), 64'd1);
        end
        wait_idle("t4");
        check("t4_rd_pulses", 64'(rd_cnt), 64'(base_rd + 3));

        // T5: reset in the middle of a read frame
        e = rand_entry(1'b0);
        base_wr = wr_q.size();
        push_entry(e, $urandom);
        viol_a = 0;
        while (!(st_n == next_frame && mon_edges >= 20) && viol_a < 1000) begin
            tick();
            viol_a++;
        end
        check("t5_reach_bit20", 64'(mon_edges >= 20), 64'd1);
        #1;
        HRESETn = 1'b0;
        #1;
        check("t5_cs_n",  64'(SPI_CS_n), 64'd1);
        check("t5_sclk",  64'(SPI_SCLK), 64'd0);
        check("t5_mosi",  64'(SPI_MOSI), 64'd0);
        check("t5_busy",  64'(SPI_busy), 64'd0);
        void'(exp_rd.pop_back());
        repeat (3) tick();
        HRESETn = 1'b1;
        tick();
        e = rand_entry(1'b1);
        push_entry(e, 32'h0);
        wait_frames(7, "t5");
        check_frame(6, e, "t5_after");
        wait_idle("t5");
        check("t5_no_push", 64'(wr_q.size()), 64'(base_wr));

        // T6: empty write FIFO for 100 cycles
        base_rd = rd_cnt;
        viol_a = 0;
        viol_b = 0;
        viol_c = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (WriteFIFO_rd_en !== 1'b0) viol_a++;
            if (SPI_CS_n !== 1'b1) viol_b++;
            if (SPI_busy !== 1'b0) viol_c++;
        end
        check("t6_no_rd_en", 64'(viol_a), 64'd0);
        check("t6_cs_high",  64'(viol_b), 64'd0);
        check("t6_not_busy", 64'(viol_c), 64'd0);
        check("t6_rd_count", 64'(rd_cnt), 64'(base_rd));

        // T7: a further random batch
        for (int i = 0; i < 3; i++) begin
            e4[i] = rand_entry(1'($urandom_range(1)));
            push_entry(e4[i], $urandom);
        end
        wait_frames(10, "t7");
        for (int i = 0; i < 3; i++) check_frame(7 + i, e4[i], $sformatf("t7_f%0d", i));
        wait_idle("t7");

        // Every read response, in order, against the slave model's answers.
        check("rd_push_total", 64'(wr_q.size()), 64'(exp_rd.size()));
        for (int i = 0; i < wr_q.size() && i < exp_rd.size(); i++)
            check($sformatf("rd_data%0d", i), 64'(wr_q[i]), 64'(exp_rd[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #(50000 * T);
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "time limit reached");
    end

endmodule
